// File: rtl/mor1kx_branch_predictor_gshare_param_if.sv
// mor1kx_branch_predictor_gshare_param_if: decode/execute signals between pipeline and branch predictor
interface mor1kx_branch_predictor_gshare_param_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  logic                            op_bf_i;
  logic                            op_bnf_i;
  logic [9:0]                      immjbr_upper_i;
  logic [OPTION_OPERAND_WIDTH-1:0] pc_i;
  logic                            padv_decode_i;
  logic                            predicted_flag_o;
  logic                            table_ready_o;
  logic                            execute_op_brcond_i;
  logic                            flag_i;
  logic                            execute_op_bf_i;
  modport master (
    output op_bf_i, op_bnf_i, immjbr_upper_i, pc_i, padv_decode_i,
    output execute_op_brcond_i, flag_i, execute_op_bf_i,
    input  predicted_flag_o, table_ready_o
  );
  modport slave (
    input  op_bf_i, op_bnf_i, immjbr_upper_i, pc_i, padv_decode_i,
    input  execute_op_brcond_i, flag_i, execute_op_bf_i,
    output predicted_flag_o, table_ready_o
  );
endinterface

// File: rtl/mor1kx_branch_predictor_gshare_param.sv
// mor1kx_branch_predictor_gshare_param: gshare/bimodal conditional-branch predictor with post-reset table clear
module mor1kx_branch_predictor_gshare_param #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TABLE_AW             = 6,
  parameter int COUNTER_BITS         = 2,
  parameter int HISTORY_BITS         = 4
) (
  input logic clk,
  input logic rst,
  mor1kx_branch_predictor_gshare_param_if.slave bp
);
  localparam logic [COUNTER_BITS-1:0] WEAK_NT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nx;
  logic [TABLE_AW-1:0] clr_cnt, saved_idx, idx, hist, wa;
  logic [COUNTER_BITS-1:0] cnt_tbl [1 << TABLE_AW];
  logic [COUNTER_BITS-1:0] cur, wd;
  logic we, update, actual_taken, taken, capture;
  logic unused_inputs;
  assign unused_inputs = ^{bp.pc_i, bp.immjbr_upper_i[8:0]};
  assign bp.table_ready_o = state == READY;
  assign idx = bp.pc_i[2 +: TABLE_AW] ^ hist;
  assign taken = cnt_tbl[idx][COUNTER_BITS-1];
  assign capture = bp.padv_decode_i & (bp.op_bf_i | bp.op_bnf_i);
  assign update = bp.execute_op_brcond_i & bp.table_ready_o;
  assign actual_taken = bp.execute_op_bf_i ? bp.flag_i : ~bp.flag_i;
  assign cur = cnt_tbl[saved_idx];
  assign bp.predicted_flag_o = bp.table_ready_o ?
                               (bp.op_bf_i & taken | bp.op_bnf_i & ~taken) :
                               (bp.op_bf_i & bp.immjbr_upper_i[9] | bp.op_bnf_i & ~bp.immjbr_upper_i[9]);
  always_comb begin
    state_nx = (state == CLEAR && &clr_cnt) ? READY : state;
    we = ~rst & (state == CLEAR | update);
    wa = state == CLEAR ? clr_cnt : saved_idx;
    wd = state == CLEAR ? WEAK_NT :
         actual_taken   ? (&cur ? cur : cur + 1'b1) :
                          (|cur ? cur - 1'b1 : cur);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      saved_idx <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (capture) saved_idx <= idx;
    end
  // Single write port: the clear sweep and outcome updates never overlap.
  always_ff @(posedge clk)
    if (we) cnt_tbl[wa] <= wd;
  if (HISTORY_BITS == 0) begin : g_bimodal
    assign hist = '0;
  end else begin : g_ghr
    logic [HISTORY_BITS-1:0] ghr;
    always_ff @(posedge clk)
      if (rst) ghr <= '0;
      else if (update) ghr <= HISTORY_BITS'({ghr, actual_taken});
    assign hist = TABLE_AW'(ghr);
  end
endmodule

// File: tb/tb_mor1kx_branch_predictor_gshare_param.sv
// tb_mor1kx_branch_predictor_gshare_param: directed checks of clear sweep, saturation, polarity, capture/update overlap and history
module tb_mor1kx_branch_predictor_gshare_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic p0, p1;
  always #5 clk = ~clk;
  mor1kx_branch_predictor_gshare_param_if #(.OPTION_OPERAND_WIDTH(32)) b0 ();
  mor1kx_branch_predictor_gshare_param_if #(.OPTION_OPERAND_WIDTH(32)) b1 ();
  assign b1.op_bf_i             = b0.op_bf_i;
  assign b1.op_bnf_i            = b0.op_bnf_i;
  assign b1.immjbr_upper_i      = b0.immjbr_upper_i;
  assign b1.pc_i                = b0.pc_i;
  assign b1.padv_decode_i       = b0.padv_decode_i;
  assign b1.execute_op_brcond_i = b0.execute_op_brcond_i;
  assign b1.flag_i              = b0.flag_i;
  assign b1.execute_op_bf_i     = b0.execute_op_bf_i;
  mor1kx_branch_predictor_gshare_param #(
    .OPTION_OPERAND_WIDTH(32), .TABLE_AW(6), .COUNTER_BITS(2), .HISTORY_BITS(4)
  ) u0 (.clk(clk), .rst(rst), .bp(b0));
  mor1kx_branch_predictor_gshare_param #(
    .OPTION_OPERAND_WIDTH(32), .TABLE_AW(6), .COUNTER_BITS(2), .HISTORY_BITS(0)
  ) u1 (.clk(clk), .rst(rst), .bp(b1));
  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic probe(input logic bf, input logic bnf, input logic [31:0] pc);
    b0.op_bf_i = bf;
    b0.op_bnf_i = bnf;
    b0.pc_i = pc;
    b0.padv_decode_i = 1'b0;
    b0.execute_op_brcond_i = 1'b0;
    #1;
    p0 = b0.predicted_flag_o;
    p1 = b1.predicted_flag_o;
  endtask
  task automatic branch(input logic bf, input logic bnf, input logic [31:0] pc, input logic flag);
    b0.op_bf_i = bf;
    b0.op_bnf_i = bnf;
    b0.pc_i = pc;
    b0.padv_decode_i = 1'b1;
    b0.execute_op_brcond_i = 1'b0;
    #1;
    p0 = b0.predicted_flag_o;
    p1 = b1.predicted_flag_o;
    tick;
    b0.op_bf_i = 1'b0;
    b0.op_bnf_i = 1'b0;
    b0.padv_decode_i = 1'b0;
    b0.execute_op_brcond_i = 1'b1;
    b0.flag_i = flag;
    b0.execute_op_bf_i = bf;
    tick;
    b0.execute_op_brcond_i = 1'b0;
  endtask
  initial begin
    b0.op_bf_i = 1'b0;
    b0.op_bnf_i = 1'b0;
    b0.immjbr_upper_i = 10'h000;
    b0.pc_i = 32'h0;
    b0.padv_decode_i = 1'b0;
    b0.execute_op_brcond_i = 1'b0;
    b0.flag_i = 1'b0;
    b0.execute_op_bf_i = 1'b0;
    tick;
    tick;
    chk("reset_ready_u0", b0.table_ready_o, 1'b0);
    chk("reset_ready_u1", b1.table_ready_o, 1'b0);
    rst = 1'b0;
    b0.immjbr_upper_i = 10'h200;
    probe(1'b1, 1'b0, 32'h100); chk("static_bf_back", p0, 1'b1);
    b0.immjbr_upper_i = 10'h000;
    probe(1'b1, 1'b0, 32'h100); chk("static_bf_fwd", p0, 1'b0);
    probe(1'b0, 1'b1, 32'h100); chk("static_bnf_fwd", p0, 1'b1);
    b0.immjbr_upper_i = 10'h200;
    probe(1'b0, 1'b1, 32'h100); chk("static_bnf_back", p0, 1'b0);
    probe(1'b0, 1'b0, 32'h100); chk("static_none", p0, 1'b0);
    b0.op_bf_i = 1'b1;
    b0.pc_i = 32'h100;
    b0.padv_decode_i = 1'b1;
    b0.execute_op_brcond_i = 1'b1;
    b0.flag_i = 1'b1;
    b0.execute_op_bf_i = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick;
      chk("sweep_ready_u0", b0.table_ready_o, i == 64);
      chk("sweep_ready_u1", b1.table_ready_o, i == 64);
      chk("sweep_pred", b0.predicted_flag_o, i < 64);
    end
    b0.execute_op_brcond_i = 1'b0;
    b0.padv_decode_i = 1'b0;
    probe(1'b1, 1'b0, 32'h100);
    chk("cleared_weak_nt_u0", p0, 1'b0);
    chk("cleared_weak_nt_u1", p1, 1'b0);
    branch(1'b1, 1'b0, 32'h100, 1'b1); chk("sat_first_pred", p1, 1'b0);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    probe(1'b1, 1'b0, 32'h100); chk("sat_4taken", p1, 1'b1);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    probe(1'b1, 1'b0, 32'h100); chk("sat_5th_taken", p1, 1'b1);
    branch(1'b1, 1'b0, 32'h100, 1'b0);
    probe(1'b1, 1'b0, 32'h100); chk("sat_dec1", p1, 1'b1);
    branch(1'b1, 1'b0, 32'h100, 1'b0);
    probe(1'b1, 1'b0, 32'h100); chk("sat_dec2", p1, 1'b0);
    branch(1'b1, 1'b0, 32'h100, 1'b0);
    branch(1'b1, 1'b0, 32'h100, 1'b0);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    probe(1'b1, 1'b0, 32'h100); chk("floor_hold", p1, 1'b0);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    probe(1'b1, 1'b0, 32'h100); chk("floor_recover", p1, 1'b1);
    branch(1'b1, 1'b0, 32'h100, 1'b1);
    probe(1'b0, 1'b1, 32'h100); chk("bnf_on_taken", p1, 1'b0);
    probe(1'b1, 1'b0, 32'h100); chk("bf_on_taken", p1, 1'b1);
    branch(1'b0, 1'b1, 32'h104, 1'b0);
    probe(1'b1, 1'b0, 32'h104); chk("bnf_flag0_taken", p1, 1'b1);
    probe(1'b0, 1'b1, 32'h104); chk("bnf_flag0_bnf", p1, 1'b0);
    branch(1'b0, 1'b1, 32'h104, 1'b1);
    probe(1'b1, 1'b0, 32'h104); chk("bnf_flag1_nt", p1, 1'b0);
    b0.op_bf_i = 1'b1;
    b0.pc_i = 32'h10C;
    b0.padv_decode_i = 1'b1;
    tick;
    b0.pc_i = 32'h108;
    b0.execute_op_brcond_i = 1'b1;
    b0.flag_i = 1'b1;
    b0.execute_op_bf_i = 1'b1;
    tick;
    probe(1'b1, 1'b0, 32'h10C); chk("simul_b_updated", p1, 1'b1);
    probe(1'b1, 1'b0, 32'h108); chk("simul_a_untouched", p1, 1'b0);
    b0.execute_op_brcond_i = 1'b1;
    tick;
    b0.execute_op_brcond_i = 1'b0;
    probe(1'b1, 1'b0, 32'h108); chk("simul_a_captured", p1, 1'b1);
    rst = 1'b1;
    tick;
    chk("rst2_ready", b0.table_ready_o, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      chk("partial_sweep_ready", b0.table_ready_o, 1'b0);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    b0.op_bf_i = 1'b1;
    b0.pc_i = 32'h100;
    b0.padv_decode_i = 1'b1;
    b0.execute_op_brcond_i = 1'b1;
    b0.flag_i = 1'b1;
    b0.execute_op_bf_i = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick;
      chk("midreset_ready_u0", b0.table_ready_o, i == 64);
      chk("midreset_ready_u1", b1.table_ready_o, i == 64);
    end
    b0.execute_op_brcond_i = 1'b0;
    b0.padv_decode_i = 1'b0;
    probe(1'b1, 1'b0, 32'h100); chk("midreset_updates_ignored", p1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      branch(1'b1, 1'b0, 32'h100, k % 2 == 0);
      if (k >= 8) chk("history_alternating", p0, k % 2 == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mor1kx_branch_predictor_gshare_param.md
Name: mor1kx_branch_predictor_gshare_param

Overview:
Parametrised dynamic conditional-branch predictor for the mor1kx decode/execute pipeline. It replaces the static backward-taken/forward-not-taken rule with a table of saturating counters. The table is indexed by PC bits XORed with a global history register; with HISTORY_BITS=0 it degenerates to a bimodal predictor. The decode stage reads a prediction and the execute stage writes back the resolved outcome. A post-reset table-clear sweep runs for 2^TABLE_AW cycles, and the static rule is used until the sweep completes.

Parameters:
OPTION_OPERAND_WIDTH, 32, width of pc_i
TABLE_AW, 6, log2 of counter-table depth (legal range 1..12)
COUNTER_BITS, 2, width of each saturating counter (legal range 1..4)
HISTORY_BITS, 4, global history length (legal range 0..TABLE_AW; 0 means bimodal)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
op_bf_i  in  1  decode stage: instruction is l.bf
op_bnf_i  in  1  decode stage: instruction is l.bnf
immjbr_upper_i  in  10  decode stage: upper branch-offset bits; bit 9 is the sign
pc_i  in  OPTION_OPERAND_WIDTH  decode-stage PC
padv_decode_i  in  1  decode stage advances this cycle
predicted_flag_o  out  1  predicted SR[F] value for the decode-stage branch
table_ready_o  out  1  clear sweep done; dynamic prediction active
execute_op_brcond_i  in  1  the execute-stage instruction is the branch last captured
flag_i  in  1  resolved SR[F] of the execute-stage branch
execute_op_bf_i  in  1  execute-stage branch is l.bf (0 means l.bnf)

Behaviour:
- Index: idx = pc_i[2 +: TABLE_AW] XOR {zeros, ghr[HISTORY_BITS-1:0]}, with ghr aligned to the LSBs.
- A counter value >= 2^(COUNTER_BITS-1) means predict taken.
- Prediction is combinational from the registered table, ghr and the decode inputs. No same-cycle write bypass: a read of an entry being written returns the old value.
- With table_ready_o=1: predicted_flag_o = op_bf_i & taken | op_bnf_i & ~taken.
- With table_ready_o=0: static rule, predicted_flag_o = op_bf_i & immjbr_upper_i[9] | op_bnf_i & ~immjbr_upper_i[9].
- predicted_flag_o = 0 whenever op_bf_i and op_bnf_i are both 0.
- Capture: on padv_decode_i & (op_bf_i|op_bnf_i), register idx into saved_idx.
- Update: on execute_op_brcond_i & table_ready_o:
  - actual_taken = execute_op_bf_i ? flag_i : ~flag_i.
  - table[saved_idx] is incremented if taken (saturating at all-ones) or decremented if not taken (saturating at 0).
  - ghr <= {ghr[HISTORY_BITS-2:0], actual_taken}.
- Update is ignored (no counter or ghr change) while table_ready_o=0.
- Simultaneous capture and update in one cycle: the update uses the pre-edge saved_idx; the capture writes the new saved_idx at the same edge.
- FSM states:
  - CLEAR: writes table[clr_cnt] <= 2^(COUNTER_BITS-1)-1 (weakly not-taken; 0 when COUNTER_BITS=1), then clr_cnt++. After the write to entry 2^TABLE_AW-1, goes to READY.
  - READY: normal operation. Terminal until reset.
- Reset (any cycle, including mid-sweep): state <= CLEAR, clr_cnt <= 0, ghr <= 0, saved_idx <= 0, table_ready_o <= 0.
- predicted_flag_o has no reset value (combinational). Table contents are undefined until the sweep writes them.
- table_ready_o rises exactly 2^TABLE_AW cycles after the first clock edge with rst low.
- HISTORY_BITS=0: no ghr logic; idx = pc bits only.
- HISTORY_BITS=1: shift reduces to ghr <= actual_taken.
- Width rules: counter arithmetic stays in COUNTER_BITS bits with no wrap-around. idx is exactly TABLE_AW bits.

Test Plan:
- Reset sweep (TABLE_AW=6): deassert rst → table_ready_o=0 for 64 cycles, 1 on cycle 64. During the sweep, l.bf with immjbr_upper_i[9]=1 predicts 1; l.bnf with sign 0 predicts 1.
- Saturation (COUNTER_BITS=2, HISTORY_BITS=0, pc=0x100): 4 taken l.bf updates → prediction 1 with counter at 3; a 5th taken update leaves it at 3; then 2 not-taken updates → prediction 0.
- History aliasing (HISTORY_BITS=4): alternating taken/not-taken pattern at a single pc, 40 iterations → after warm-up the prediction matches the outcome 100%.
- Simultaneous capture and update: capture pc A with an update pending for pc B in the same cycle → B's entry changes and A's entry does not.
- Reset mid-sweep at clr_cnt=30 → table_ready_o stays 0 for a full 64 further cycles; updates issued during that window have no effect.
- l.bnf polarity: after a trained taken counter at a pc, l.bnf there predicts flag 0. An update with flag_i=0 on l.bnf counts as taken.
